// File: rtl/sram_like_arbiter.sv
// ============================================================================
// sram_like_arbiter: two sram-like requesters (inst, data) onto one master.
// Optional build macro: SRAM_LIKE_ARB_STARVE_GUARD_EN (bounded inst starvation)
// Revision: 1.0
// ============================================================================
`default_nettype none

module sram_like_arbiter #(
  parameter int MAX_STARVE = 4,
  parameter int AW         = 32,
  parameter int DW         = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inst_req,
  input  logic          inst_wr,
  input  logic [1:0]    inst_size,
  input  logic [AW-1:0] inst_addr,
  input  logic [DW-1:0] inst_wdata,
  output logic          inst_addr_ok,
  output logic          inst_data_ok,
  output logic [DW-1:0] inst_rdata,
  input  logic          data_req,
  input  logic          data_wr,
  input  logic [1:0]    data_size,
  input  logic [AW-1:0] data_addr,
  input  logic [DW-1:0] data_wdata,
  output logic          data_addr_ok,
  output logic          data_data_ok,
  output logic [DW-1:0] data_rdata,
  output logic          m_req,
  output logic          m_wr,
  output logic [1:0]    m_size,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic          m_addr_ok,
  input  logic          m_data_ok,
  input  logic [DW-1:0] m_rdata,
  output logic [1:0]    grant,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic          wr_q, wr_d;
  logic [1:0]    size_q, size_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          w_pick_inst;
  logic          w_arb;
  logic          w_addr_hs;
  logic          w_data_hs;

  if (MAX_STARVE < 1) begin : g_bad_cfg
    $error("sram_like_arbiter: MAX_STARVE must be at least 1");
  end

  assign w_arb = inst_req || data_req;

`ifdef SRAM_LIKE_ARB_STARVE_GUARD_EN
  localparam int SW = (MAX_STARVE < 8) ? 3 : $clog2(MAX_STARVE + 1);

  logic [SW-1:0] starve_q, starve_d;

  // Counter saturates at MAX_STARVE so the forced-inst condition stays armed.
  assign w_pick_inst = inst_req && (!data_req || (starve_q == SW'(MAX_STARVE)));

  always_comb begin
    starve_d = starve_q;
    if (state_q == IDLE && w_arb) begin
      if (w_pick_inst) begin
        starve_d = '0;
      end else if (inst_req && (starve_q != SW'(MAX_STARVE))) begin
        starve_d = starve_q + SW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign w_pick_inst = inst_req && !data_req;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    wr_d    = wr_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (w_arb) begin
          state_d = ADDR;
          grant_d = w_pick_inst ? 2'b01 : 2'b10;
          wr_d    = w_pick_inst ? inst_wr    : data_wr;
          size_d  = w_pick_inst ? inst_size  : data_size;
          addr_d  = w_pick_inst ? inst_addr  : data_addr;
          wdata_d = w_pick_inst ? inst_wdata : data_wdata;
        end
      end
      ADDR: begin
        if (m_addr_ok) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (m_data_ok) begin
          state_d = IDLE;
          grant_d = 2'b00;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      wr_q    <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Handshakes are honoured only in the state that expects them.
  assign w_addr_hs = (state_q == ADDR) && m_addr_ok;
  assign w_data_hs = (state_q == WAIT) && m_data_ok;

  assign inst_addr_ok = w_addr_hs && grant_q[0];
  assign data_addr_ok = w_addr_hs && grant_q[1];
  assign inst_data_ok = w_data_hs && grant_q[0];
  assign data_data_ok = w_data_hs && grant_q[1];
  assign inst_rdata   = inst_data_ok ? m_rdata : '0;
  assign data_rdata   = data_data_ok ? m_rdata : '0;

  assign m_req   = (state_q == ADDR);
  assign m_wr    = wr_q;
  assign m_size  = size_q;
  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;
  assign grant   = grant_q;
  assign busy    = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_sram_like_arbiter.sv
// ============================================================================
// tb_sram_like_arbiter: scoreboard bench with a latency-programmable slave.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sram_like_arbiter;

  localparam int          AW     = 32;
  localparam int          DW     = 32;
  localparam logic [31:0] RD_KEY = 32'h83DD_0001;

  logic          clk = 1'b0;
  logic          rst;
  logic          inst_req, inst_wr, data_req, data_wr;
  logic [1:0]    inst_size, data_size;
  logic [AW-1:0] inst_addr, data_addr;
  logic [DW-1:0] inst_wdata, data_wdata;
  logic          inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [DW-1:0] inst_rdata, data_rdata;
  logic          m_req, m_wr, m_addr_ok, m_data_ok;
  logic [1:0]    m_size, grant;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic          busy;

  always #5 clk = ~clk;

  sram_like_arbiter #(.MAX_STARVE(4), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
    .grant(grant), .busy(busy)
  );

  typedef struct {
    logic        side;   // 0 = inst, 1 = data
    logic [31:0] rdata;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   inst_aok_cnt = 0, data_aok_cnt = 0, inst_dok_cnt = 0, data_dok_cnt = 0;
  bit   keep_inst = 0, keep_data = 0, drop_inst = 0, drop_data = 0;
  int   addr_lat = 1, data_lat = 2, rsp_cnt = 0;
  bit   rsp_phase = 0, stray_dok = 0;
  logic [31:0] rsp_addr = '0;

  task automatic push_exp(input logic side, input logic [31:0] addr);
    exp_t e;
    e.side  = side;
    e.rdata = addr ^ RD_KEY;
    sb_q.push_back(e);
  endtask

  // One clock: score outputs at negedge, then requester drops and slave model.
  task automatic clk_cycle();
    exp_t        e;
    logic        gs;
    logic [31:0] gr, oth;
    @(negedge clk);
    if (inst_addr_ok) begin
      inst_aok_cnt++;
      n_vec++;
      if (grant !== 2'b01 || data_addr_ok !== 1'b0) begin
        n_err++;
        $display("FAIL addr_ok_owner: inst_addr_ok with grant=%b data_addr_ok=%b, required 01/0", grant, data_addr_ok);
      end
      if (!keep_inst) drop_inst = 1;
    end
    if (data_addr_ok) begin
      data_aok_cnt++;
      n_vec++;
      if (grant !== 2'b10) begin
        n_err++;
        $display("FAIL addr_ok_owner: data_addr_ok with grant=%b, required 10", grant);
      end
      if (!keep_data) drop_data = 1;
    end
    if (inst_data_ok || data_data_ok) begin
      n_vec++;
      if (inst_data_ok && data_data_ok) begin
        n_err++;
        $display("FAIL data_ok_both: both data_ok high, required one");
      end else if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL data_ok_unexpected: inst=%b data=%b, required none", inst_data_ok, data_data_ok);
      end else begin
        e   = sb_q.pop_front();
        gs  = data_data_ok;
        gr  = gs ? data_rdata : inst_rdata;
        oth = gs ? inst_rdata : data_rdata;
        if (gs !== e.side || gr !== e.rdata || oth !== 32'h0) begin
          n_err++;
          $display("FAIL scoreboard: side=%0d rdata=%h other=%h, required side=%0d rdata=%h other=0",
                   gs, gr, oth, e.side, e.rdata);
        end
      end
      if (inst_data_ok) inst_dok_cnt++;
      if (data_data_ok) data_dok_cnt++;
    end
    @(posedge clk);
    #1;
    if (drop_inst) begin inst_req = 0; drop_inst = 0; end
    if (drop_data) begin data_req = 0; drop_data = 0; end
    m_addr_ok = 0;
    m_data_ok = 0;
    m_rdata   = '0;
    if (rst) begin
      rsp_phase = 0;
      rsp_cnt   = 0;
    end else if (!rsp_phase) begin
      if (m_req) begin
        if (rsp_cnt == addr_lat) begin
          m_addr_ok = 1;
          rsp_addr  = m_addr;
          rsp_phase = 1;
          rsp_cnt   = 0;
        end else begin
          rsp_cnt++;
        end
      end
    end else begin
      rsp_cnt++;
      if (rsp_cnt >= data_lat) begin
        m_data_ok = 1;
        m_rdata   = rsp_addr ^ RD_KEY;
        rsp_phase = 0;
        rsp_cnt   = 0;
      end
    end
    if (stray_dok && !m_data_ok) begin
      m_data_ok = 1;
      m_rdata   = 32'hBAD0_BAD0;
    end
  endtask

  task automatic test_reset();
    rst = 1;
    inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
    m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
    repeat (3) clk_cycle();
    n_vec++;
    if ({grant, busy, m_req} !== 4'b0) begin
      n_err++;
      $display("FAIL reset_state: grant=%b busy=%b m_req=%b, required 00/0/0", grant, busy, m_req);
    end
    n_vec++;
    if ({inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok} !== 4'b0 ||
        inst_rdata !== 32'h0 || data_rdata !== 32'h0) begin
      n_err++;
      $display("FAIL reset_resp: oks=%b%b%b%b rdata=%h/%h, required zeros",
               inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, inst_rdata, data_rdata);
    end
    n_vec++;
    if (m_addr !== 32'h0 || m_wdata !== 32'h0 || m_wr !== 1'b0 || m_size !== 2'b0) begin
      n_err++;
      $display("FAIL reset_capture: m_addr=%h m_wdata=%h m_wr=%b m_size=%0d, required zeros",
               m_addr, m_wdata, m_wr, m_size);
    end
    rst = 0;
    clk_cycle();
  endtask

  task automatic test_single_inst();
    int i0 = inst_dok_cnt, ia0 = inst_aok_cnt, d0 = data_aok_cnt + data_dok_cnt;
    int first = -1;
    addr_lat = 1; data_lat = 2;
    inst_req = 1; inst_wr = 0; inst_size = 2; inst_addr = 32'hBFC0_0000;
    push_exp(0, 32'hBFC0_0000);
    for (int i = 0; i < 20 && inst_dok_cnt == i0; i++) begin
      clk_cycle();
      if (m_req && first < 0) begin
        first = i;
        n_vec++;
        if (m_addr !== 32'hBFC0_0000 || m_size !== 2'd2 || m_wr !== 1'b0 || grant !== 2'b01) begin
          n_err++;
          $display("FAIL single_fields: addr=%h size=%0d wr=%b grant=%b, required bfc00000/2/0/01",
                   m_addr, m_size, m_wr, grant);
        end
      end
    end
    n_vec++;
    if (first != 0) begin
      n_err++;
      $display("FAIL single_latency: m_req after %0d extra cycles, required 0", first);
    end
    n_vec++;
    if (inst_dok_cnt != i0 + 1 || inst_aok_cnt != ia0 + 1) begin
      n_err++;
      $display("FAIL single_count: addr_ok=%0d data_ok=%0d, required 1/1",
               inst_aok_cnt - ia0, inst_dok_cnt - i0);
    end
    n_vec++;
    if (grant !== 2'b00 || busy !== 1'b0 || data_aok_cnt + data_dok_cnt != d0) begin
      n_err++;
      $display("FAIL single_after: grant=%b busy=%b data_pulses=%0d, required 00/0/0",
               grant, busy, data_aok_cnt + data_dok_cnt - d0);
    end
  endtask

  task automatic test_simultaneous();
    int i0 = inst_dok_cnt, d0 = data_dok_cnt, ia0 = inst_aok_cnt, da0 = data_aok_cnt;
    bit seen_d = 0, seen_i = 0;
    addr_lat = 1; data_lat = 1;
    inst_req = 1; inst_wr = 0; inst_size = 2; inst_addr = 32'hBFC0_0004;
    data_req = 1; data_wr = 1; data_size = 2; data_addr = 32'h8000_0010; data_wdata = 32'hDEAD_BEEF;
    push_exp(1, 32'h8000_0010);
    push_exp(0, 32'hBFC0_0004);
    for (int i = 0; i < 40 && (inst_dok_cnt == i0 || data_dok_cnt == d0); i++) begin
      clk_cycle();
      if (m_req && !seen_d) begin
        seen_d = 1;
        n_vec++;
        if (grant !== 2'b10 || m_wr !== 1'b1 || m_wdata !== 32'hDEAD_BEEF || m_addr !== 32'h8000_0010) begin
          n_err++;
          $display("FAIL simul_first: grant=%b wr=%b wdata=%h addr=%h, required 10/1/deadbeef/80000010",
                   grant, m_wr, m_wdata, m_addr);
        end
      end else if (m_req && grant == 2'b01 && !seen_i) begin
        seen_i = 1;
        n_vec++;
        if (m_wr !== 1'b0 || m_addr !== 32'hBFC0_0004) begin
          n_err++;
          $display("FAIL simul_second: wr=%b addr=%h, required 0/bfc00004", m_wr, m_addr);
        end
      end
    end
    n_vec++;
    if (inst_aok_cnt != ia0 + 1 || data_aok_cnt != da0 + 1 ||
        inst_dok_cnt != i0 + 1 || data_dok_cnt != d0 + 1 || !seen_i) begin
      n_err++;
      $display("FAIL simul_count: aok i/d=%0d/%0d dok i/d=%0d/%0d, required 1/1 1/1",
               inst_aok_cnt - ia0, data_aok_cnt - da0, inst_dok_cnt - i0, data_dok_cnt - d0);
    end
  endtask

  task automatic test_stall();
    int d0 = data_dok_cnt, nreq = 0;
    addr_lat = 10; data_lat = 1;
    data_req = 1; data_wr = 1; data_size = 1; data_addr = 32'h8000_0100; data_wdata = 32'h1234_5678;
    push_exp(1, 32'h8000_0100);
    for (int i = 0; i < 40 && data_dok_cnt == d0; i++) begin
      clk_cycle();
      if (i == 5) data_req = 0;
      if (m_req) begin
        nreq++;
        n_vec++;
        if (m_addr !== 32'h8000_0100 || m_wdata !== 32'h1234_5678 || m_wr !== 1'b1 || m_size !== 2'd1) begin
          n_err++;
          $display("FAIL stall_stable: addr=%h wdata=%h wr=%b size=%0d, required 80000100/12345678/1/1",
                   m_addr, m_wdata, m_wr, m_size);
        end
      end
    end
    n_vec++;
    if (nreq != 11 || data_dok_cnt != d0 + 1) begin
      n_err++;
      $display("FAIL stall_count: m_req cycles=%0d data_ok=%0d, required 11/1", nreq, data_dok_cnt - d0);
    end
  endtask

  task automatic test_stray();
    int i0 = inst_dok_cnt, d0 = data_dok_cnt;
    addr_lat = 3; data_lat = 1;
    stray_dok = 1;
    repeat (3) clk_cycle();
    stray_dok = 0;
    clk_cycle();
    n_vec++;
    if (busy !== 1'b0 || grant !== 2'b00 || inst_dok_cnt != i0 || data_dok_cnt != d0) begin
      n_err++;
      $display("FAIL stray_idle: busy=%b grant=%b data_ok pulses=%0d, required 0/00/0",
               busy, grant, inst_dok_cnt - i0 + data_dok_cnt - d0);
    end
    inst_req = 1; inst_wr = 0; inst_size = 0; inst_addr = 32'hBFC0_0200;
    push_exp(0, 32'hBFC0_0200);
    clk_cycle();
    stray_dok = 1;
    clk_cycle();
    stray_dok = 0;
    clk_cycle();
    n_vec++;
    if (m_req !== 1'b1 || busy !== 1'b1 || grant !== 2'b01 || inst_dok_cnt != i0) begin
      n_err++;
      $display("FAIL stray_addr: m_req=%b busy=%b grant=%b data_ok=%0d, required 1/1/01/0",
               m_req, busy, grant, inst_dok_cnt - i0);
    end
    for (int i = 0; i < 20 && inst_dok_cnt == i0; i++) clk_cycle();
    n_vec++;
    if (inst_dok_cnt != i0 + 1) begin
      n_err++;
      $display("FAIL stray_complete: data_ok=%0d, required 1", inst_dok_cnt - i0);
    end
  endtask

  task automatic test_reset_in_wait();
    int  d0 = data_dok_cnt;
    bit  in_wait = 0;
    addr_lat = 0; data_lat = 50;
    data_req = 1; data_wr = 0; data_size = 2; data_addr = 32'h8000_0300;
    for (int i = 0; i < 10 && !in_wait; i++) begin
      clk_cycle();
      in_wait = busy && !m_req && grant == 2'b10;
    end
    n_vec++;
    if (!in_wait) begin
      n_err++;
      $display("FAIL rstwait_reach: busy=%b m_req=%b grant=%b, required WAIT", busy, m_req, grant);
    end
    rst = 1; data_req = 0;
    clk_cycle();
    rst = 0;
    stray_dok = 1;
    repeat (2) clk_cycle();
    stray_dok = 0;
    clk_cycle();
    n_vec++;
    if (data_dok_cnt != d0 || grant !== 2'b00 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL rstwait_after: data_ok=%0d grant=%b busy=%b, required 0/00/0",
               data_dok_cnt - d0, grant, busy);
    end
  endtask

  task automatic test_starvation();
    int ia0 = inst_aok_cnt, i0 = inst_dok_cnt, d0 = data_dok_cnt;
    addr_lat = 0; data_lat = 1;
    keep_data = 1;
    data_req = 1; data_wr = 0; data_size = 2; data_addr = 32'h8000_0400;
    inst_req = 1; inst_wr = 0; inst_size = 2; inst_addr = 32'hBFC0_0300;
`ifdef SRAM_LIKE_ARB_STARVE_GUARD_EN
    for (int k = 0; k < 4; k++) push_exp(1, 32'h8000_0400);
    push_exp(0, 32'hBFC0_0300);
    for (int i = 0; i < 100 && inst_dok_cnt == i0; i++) clk_cycle();
    data_req = 0; keep_data = 0;
    n_vec++;
    if (inst_dok_cnt != i0 + 1 || data_dok_cnt != d0 + 4) begin
      n_err++;
      $display("FAIL starve_guard: data before inst=%0d inst=%0d, required 4/1",
               data_dok_cnt - d0, inst_dok_cnt - i0);
    end
`else
    for (int k = 0; k < 6; k++) push_exp(1, 32'h8000_0400);
    for (int i = 0; i < 100 && data_dok_cnt < d0 + 6; i++) clk_cycle();
    data_req = 0; keep_data = 0;
    n_vec++;
    if (inst_aok_cnt != ia0 || data_dok_cnt != d0 + 6) begin
      n_err++;
      $display("FAIL starve_strict: inst grants=%0d data=%0d, required 0/6",
               inst_aok_cnt - ia0, data_dok_cnt - d0);
    end
    push_exp(0, 32'hBFC0_0300);
    for (int i = 0; i < 20 && inst_dok_cnt == i0; i++) clk_cycle();
    n_vec++;
    if (inst_dok_cnt != i0 + 1) begin
      n_err++;
      $display("FAIL starve_release: inst data_ok=%0d, required 1", inst_dok_cnt - i0);
    end
`endif
    repeat (2) clk_cycle();
    n_vec++;
    if (busy !== 1'b0 || sb_q.size() != 0 || inst_aok_cnt != ia0 + 1) begin
      n_err++;
      $display("FAIL end_drain: busy=%b pending=%0d inst grants=%0d, required 0/0/1",
               busy, sb_q.size(), inst_aok_cnt - ia0);
    end
  endtask

  initial begin
    test_reset();
    test_single_inst();
    test_simultaneous();
    test_stall();
    test_stray();
    test_reset_in_wait();
    test_starvation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
- Arbitrates two sram-like requesters (instruction side, data side) onto one downstream sram-like master port, e.g. in front of the CPU's AXI bridge or a shared cache refill path.
- One transaction is in flight at a time. The granted requester's request fields are captured at grant, replayed downstream until addr_ok, and data_ok/rdata are routed back to the owner.
- Default policy is fixed priority, data side first; an optional starvation guard bounds instruction-side waiting.

Parameters:
- MAX_STARVE, 4, consecutive data grants that may be taken while inst_req is pending before the instruction side is forced (used only with the optional feature).
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- inst_req  in  1  instruction requester valid
- inst_wr  in  1  write flag
- inst_size  in  2  0=byte, 1=half, 2=word
- inst_addr  in  AW  address
- inst_wdata  in  DW  write data
- inst_addr_ok  out  1  address accepted
- inst_data_ok  out  1  transaction complete
- inst_rdata  out  DW  read data
- data_req, data_wr, data_size, data_addr, data_wdata  in  1/1/2/AW/DW  data requester, same meanings as the inst_ fields
- data_addr_ok, data_data_ok, data_rdata  out  1/1/DW  data requester responses
- m_req  out  1  downstream request
- m_wr  out  1  downstream write flag
- m_size  out  2  downstream size
- m_addr  out  AW  downstream address
- m_wdata  out  DW  downstream write data
- m_addr_ok  in  1  downstream address accepted
- m_data_ok  in  1  downstream transaction complete
- m_rdata  in  DW  downstream read data
- grant  out  2  owner of the in-flight transaction: bit0=inst, bit1=data, 00=none
- busy  out  1  state != IDLE

Behaviour:
- Clocking and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE; grant=00; m_req=0; all addr_ok/data_ok outputs 0; captured registers and rdata outputs 0; starvation counter 0. Reset asserted mid-transaction abandons it: no addr_ok/data_ok is issued afterwards, and any m_data_ok arriving after reset is ignored.
- States: IDLE, ADDR, WAIT.
- IDLE:
  - If data_req or inst_req, arbitrate, register the winner's wr/size/addr/wdata and grant, and go to ADDR next cycle. Arbitration latency is 1 cycle.
  - Priority: data over inst.
  - No request: stay in IDLE.
- ADDR:
  - m_req=1 with the captured fields; fields are stable for the whole state.
  - On m_addr_ok=1, the winner's *_addr_ok pulses for exactly that cycle (combinational from m_addr_ok gated by grant), and state goes to WAIT.
- WAIT:
  - m_req=0. On m_data_ok=1, the winner's *_data_ok pulses that cycle and *_rdata=m_rdata (combinational).
  - Then state goes to IDLE and grant clears next cycle. Minimum turnaround is 1 IDLE cycle between transactions.
- The non-granted requester never sees addr_ok or data_ok. Its request stays pending, and it must hold req per sram-like rules.
- m_data_ok in IDLE or ADDR is ignored; downstream guarantees data_ok arrives no earlier than the cycle after addr_ok. m_addr_ok in IDLE or WAIT is ignored.
- A requester deasserting req in ADDR does not cancel the transaction; the captured request completes and responses go to the owner.
- *_rdata for the non-owner is 0. The owner's rdata is valid only while its data_ok is high.
- Writes and reads are handled identically; m_rdata is don't-care on writes.

Optional Feature:
- Macro: SRAM_LIKE_ARB_STARVE_GUARD_EN.
- With the macro: a 3-bit saturating counter starve_cnt increments at each data grant made while inst_req=1, and clears at each inst grant.
  - When starve_cnt==MAX_STARVE and both requests are pending in IDLE, inst wins.
  - Counter width must hold MAX_STARVE.
- Without the macro: strict data-over-inst priority; no counter logic.

Test Plan:
- Single inst read: inst_req=1, addr=0xBFC00000, size=2; downstream addr_ok at cycle 2, data_ok with rdata=0x3C1D0001 at cycle 4 -> m_addr=0xBFC00000, inst_addr_ok pulses 1 cycle, inst_data_ok=1 with inst_rdata=0x3C1D0001, grant 01->00, data_* outputs stay 0.
- Simultaneous requests: inst read 0xBFC00004 and data write 0x80000010, wdata=0xDEADBEEF, size=2, both at cycle 0 -> data granted first (m_wr=1, m_wdata=0xDEADBEEF), inst completes second. Exactly one addr_ok and one data_ok per side.
- Downstream stall: m_addr_ok held 0 for 10 cycles -> m_req and m_addr stable for all 10 cycles; the requester drops req at cycle 5 -> transaction still completes to the owner.
- Stray handshakes: m_data_ok=1 in IDLE and during ADDR -> no *_data_ok pulse, state unchanged.
- Reset in WAIT: rst=1 for 1 cycle while in WAIT, then m_data_ok=1 -> no data_ok pulse, grant=00, busy=0.
- Starvation guard on, MAX_STARVE=4, data_req held high continuously, inst_req high -> inst granted as the 5th transaction. Macro off -> inst never granted while data_req stays high.
